// File: rtl/oserdes_gen_if.sv
// Parallel word handshake, shift enable and per-lane pad outputs of oserdes_gen.
interface oserdes_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1
);
  logic [DATA_WIDTH*LANES-1:0] d;
  logic                        d_last;
  logic                        d_valid;
  logic                        d_ready;
  logic                        oce;
  logic                        clr_underrun;
  logic [LANES-1:0]            oq;
  logic [LANES-1:0]            tq;
  logic                        busy;
  logic                        underrun;

  modport master (
    output d, d_last, d_valid, oce, clr_underrun,
    input  d_ready, oq, tq, busy, underrun
  );

  modport slave (
    input  d, d_last, d_valid, oce, clr_underrun,
    output d_ready, oq, tq, busy, underrun
  );
endinterface

// File: rtl/oserdes_gen.sv
// Parametrised lockstep multi-lane output serializer with a one-word holding
// register for gap-free streaming, frame-end marking and underrun detection.
module oserdes_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int LANES         = 1,
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit IDLE_VALUE    = 1'b1,
  parameter bit TRISTATE_IDLE = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  oserdes_gen_if.slave bus
);

  localparam int               CW       = $clog2(DATA_WIDTH);
  localparam int               WL       = DATA_WIDTH * LANES;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;
  localparam logic [LANES-1:0] OQ_IDLE  = {LANES{IDLE_VALUE}};
  localparam logic [LANES-1:0] TQ_IDLE  = {LANES{TRISTATE_IDLE}};

  logic [0:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WL-1:0]    hold_r;
  logic             hold_last_r;
  logic             hold_full_r;
  logic             cur_last_r;
  logic [WL-1:0]    shift_r;
  logic [LANES-1:0] oq_r;
  logic [LANES-1:0] tq_r;
  logic             underrun_r;

  logic             accept_s;
  logic             load_s;
  logic             advance_s;
  logic             finish_s;
  logic [LANES-1:0] load_bits_s;
  logic [WL-1:0]    load_rest_s;
  logic [LANES-1:0] next_bits_s;
  logic [WL-1:0]    next_rest_s;

  // Decide what the shift path does on the coming edge.
  always_comb begin
    accept_s  = bus.d_valid && !hold_full_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.oce && hold_full_r) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bus.oce) begin
          if (cnt_r == CNT_LAST) begin
            if (hold_full_r) begin
              load_s = 1'b1;
            end else begin
              finish_s = 1'b1;
            end
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          advance_s = 1'b0;
        end
      end
      default: begin
        finish_s = 1'b1;
      end
    endcase
  end

  // Per-lane first/next bit selection; the shift register keeps only unshown bits.
  always_comb begin
    load_bits_s = '0;
    load_rest_s = '0;
    next_bits_s = '0;
    next_rest_s = '0;
    for (int l = 0; l < LANES; l++) begin
      if (MSB_FIRST) begin
        load_bits_s[l] = hold_r[l*DATA_WIDTH + DATA_WIDTH - 1];
        load_rest_s[l*DATA_WIDTH +: DATA_WIDTH] = {hold_r[l*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
        next_bits_s[l] = shift_r[l*DATA_WIDTH + DATA_WIDTH - 1];
        next_rest_s[l*DATA_WIDTH +: DATA_WIDTH] = {shift_r[l*DATA_WIDTH +: DATA_WIDTH-1], 1'b0};
      end else begin
        load_bits_s[l] = hold_r[l*DATA_WIDTH];
        load_rest_s[l*DATA_WIDTH +: DATA_WIDTH] = {1'b0, hold_r[l*DATA_WIDTH+1 +: DATA_WIDTH-1]};
        next_bits_s[l] = shift_r[l*DATA_WIDTH];
        next_rest_s[l*DATA_WIDTH +: DATA_WIDTH] = {1'b0, shift_r[l*DATA_WIDTH+1 +: DATA_WIDTH-1]};
      end
    end
  end

  // Holding register: filled by the handshake, emptied by a LOAD (never both at once).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r      <= '0;
      hold_last_r <= 1'b0;
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_r      <= bus.d;
      hold_last_r <= bus.d_last;
      hold_full_r <= 1'b1;
    end else if (load_s) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // State, bit counter, shift registers and registered pad outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      shift_r    <= '0;
      cur_last_r <= 1'b0;
      oq_r       <= OQ_IDLE;
      tq_r       <= TQ_IDLE;
    end else if (load_s) begin
      state_r    <= ST_SHIFT;
      cnt_r      <= '0;
      shift_r    <= load_rest_s;
      cur_last_r <= hold_last_r;
      oq_r       <= load_bits_s;
      tq_r       <= '0;
    end else if (advance_s) begin
      cnt_r   <= cnt_r + CW'(1);
      shift_r <= next_rest_s;
      oq_r    <= next_bits_s;
    end else if (finish_s) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      oq_r    <= OQ_IDLE;
      tq_r    <= TQ_IDLE;
    end else begin
      state_r <= state_r;
    end
  end

  // Sticky underrun: a word ended with nothing queued and no frame-end mark; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 1'b0;
    end else if (finish_s && !cur_last_r) begin
      underrun_r <= 1'b1;
    end else if (bus.clr_underrun) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign bus.d_ready  = !hold_full_r;
  assign bus.busy     = (state_r == ST_SHIFT);
  assign bus.oq       = oq_r;
  assign bus.tq       = tq_r;
  assign bus.underrun = underrun_r;

endmodule

// File: tb/tb_oserdes_gen.sv
// Bench for oserdes_gen: three configurations, a bit-level scoreboard per DUT and hand-written corner sequences.
module tb_oserdes_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  logic rst_c;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [3:0] q_c[$];
  int run_a = 0, run_b = 0, run_c = 0;
  int last_a = 0, last_b = 0, last_c = 0;

  // exp holds the output sequence one nibble per bit time, earliest in the top nibble
  typedef struct {
    int          inst;
    logic [15:0] d;
    logic        last;
    int          nbits;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  oserdes_gen_if #(.DATA_WIDTH(8), .LANES(1)) a_if ();
  oserdes_gen_if #(.DATA_WIDTH(8), .LANES(1)) b_if ();
  oserdes_gen_if #(.DATA_WIDTH(4), .LANES(4)) c_if ();

  oserdes_gen #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b1), .TRISTATE_IDLE(1'b1))
    u_a (.clk(clk), .rst_n(rst_a), .bus(a_if));
  oserdes_gen #(.DATA_WIDTH(8), .LANES(1), .MSB_FIRST(1'b1), .IDLE_VALUE(1'b1), .TRISTATE_IDLE(1'b1))
    u_b (.clk(clk), .rst_n(rst_b), .bus(b_if));
  oserdes_gen #(.DATA_WIDTH(4), .LANES(4), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b1), .TRISTATE_IDLE(1'b1))
    u_c (.clk(clk), .rst_n(rst_c), .bus(c_if));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic qpush(input int inst, input logic [3:0] e);
    case (inst)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic qpop(input int inst, output logic [3:0] e);
    case (inst)
      0: e = q_a.pop_front();
      1: e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
  endtask

  function automatic logic get_ready(input int inst);
    case (inst)
      0: return a_if.d_ready;
      1: return b_if.d_ready;
      default: return c_if.d_ready;
    endcase
  endfunction

  task automatic drive(input int inst, input logic [15:0] d, input logic last, input logic valid);
    case (inst)
      0: begin a_if.d = d[7:0]; a_if.d_last = last; a_if.d_valid = valid; end
      1: begin b_if.d = d[7:0]; b_if.d_last = last; b_if.d_valid = valid; end
      default: begin c_if.d = d; c_if.d_last = last; c_if.d_valid = valid; end
    endcase
  endtask

  // Offer table entry idx; once accepted, its expected bit times go to the scoreboard.
  task automatic send(input int idx);
    int waited = 0;
    int inst   = vt[idx].inst;
    drive(inst, vt[idx].d, vt[idx].last, 1'b1);
    while (get_ready(inst) == 1'b0 && waited < 50) begin
      tick();
      waited++;
    end
    if (get_ready(inst) == 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout vec%0d: d_ready stuck at 0", idx);
      drive(inst, vt[idx].d, vt[idx].last, 1'b0);
    end else begin
      @(posedge clk);
      tick();
      drive(inst, vt[idx].d, vt[idx].last, 1'b0);
      for (int k = 0; k < vt[idx].nbits; k++) begin
        qpush(inst, vt[idx].exp[31-4*k -: 4]);
      end
    end
  endtask

  task automatic drain();
    int waited = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && waited < 300) begin
      tick();
      waited++;
    end
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d/%0d/%0d bits never shown", q_a.size(), q_b.size(), q_c.size());
    end
    tick();
  endtask

  // A driven bit time is an edge with OCE high that leaves TQ driving.
  task automatic mon_step(input int inst, input logic oce, input logic [3:0] tq, input logic [3:0] oq);
    logic [3:0] e;
    if (oce === 1'b1 && tq === 4'h0) begin
      if (qsize(inst) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_bit dut%0d: oq=0x%0h driven with nothing expected", inst, oq);
      end else begin
        qpop(inst, e);
        chk($sformatf("bit_dut%0d", inst), {28'd0, oq}, {28'd0, e});
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0, a_if.oce, {3'b000, a_if.tq}, {3'b000, a_if.oq});
    if (a_if.busy === 1'b1) run_a++;
    else begin
      if (run_a != 0) last_a = run_a;
      run_a = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    mon_step(1, b_if.oce, {3'b000, b_if.tq}, {3'b000, b_if.oq});
    if (b_if.busy === 1'b1) run_b++;
    else begin
      if (run_b != 0) last_b = run_b;
      run_b = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    mon_step(2, c_if.oce, c_if.tq, c_if.oq);
    if (c_if.busy === 1'b1) run_c++;
    else begin
      if (run_c != 0) last_c = run_c;
      run_c = 0;
    end
  end

  initial begin
    vt[0] = '{0, 16'h00A5, 1'b1, 8, 32'h1010_0101};
    vt[1] = '{1, 16'h00F0, 1'b0, 8, 32'h1111_0000};
    vt[2] = '{1, 16'h000F, 1'b0, 8, 32'h0000_1111};
    vt[3] = '{1, 16'h003C, 1'b1, 8, 32'h0011_1100};
    vt[4] = '{0, 16'h0055, 1'b0, 8, 32'h1010_1010};
    vt[5] = '{0, 16'h00C3, 1'b1, 8, 32'h1100_0011};
    vt[6] = '{2, 16'h8421, 1'b1, 4, 32'h1248_0000};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 16'h0000, 1'b0, 1'b0);
    a_if.oce = 1'b0; b_if.oce = 1'b0; c_if.oce = 1'b0;
    a_if.clr_underrun = 1'b0; b_if.clr_underrun = 1'b0; c_if.clr_underrun = 1'b0;
    repeat (3) tick();

    chk("rst_oq_a", {31'd0, a_if.oq}, 32'h1);
    chk("rst_tq_a", {31'd0, a_if.tq}, 32'h1);
    chk("rst_ready_a", {31'd0, a_if.d_ready}, 32'h1);
    chk("rst_busy_a", {31'd0, a_if.busy}, 32'h0);
    chk("rst_underrun_a", {31'd0, a_if.underrun}, 32'h0);
    chk("rst_oq_c", {28'd0, c_if.oq}, 32'hF);
    chk("rst_tq_c", {28'd0, c_if.tq}, 32'hF);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_if.oce = 1'b1; b_if.oce = 1'b1; c_if.oce = 1'b1;
    tick();

    // single LSB-first word on A, then three back-to-back MSB-first words on B
    for (int i = 0; i < 4; i++) send(i);
    drain();
    chk("single_busy_len", last_a, 32'd8);
    chk("single_end_oq", {31'd0, a_if.oq}, 32'h1);
    chk("single_end_tq", {31'd0, a_if.tq}, 32'h1);
    chk("single_underrun", {31'd0, a_if.underrun}, 32'h0);
    chk("stream_busy_len", last_b, 32'd24);
    chk("stream_end_tq", {31'd0, b_if.tq}, 32'h1);
    chk("stream_underrun", {31'd0, b_if.underrun}, 32'h0);

    // underrun: word without frame-end mark and nothing behind it
    send(4);
    repeat (8) tick();
    chk("underrun_before_end", {31'd0, a_if.underrun}, 32'h0);
    chk("busy_on_last_bit", {31'd0, a_if.busy}, 32'h1);
    tick();
    chk("underrun_at_end", {31'd0, a_if.underrun}, 32'h1);
    chk("underrun_idle_oq", {31'd0, a_if.oq}, 32'h1);
    chk("underrun_idle_tq", {31'd0, a_if.tq}, 32'h1);
    chk("underrun_busy", {31'd0, a_if.busy}, 32'h0);
    a_if.clr_underrun = 1'b1;
    tick();
    a_if.clr_underrun = 1'b0;
    chk("underrun_cleared", {31'd0, a_if.underrun}, 32'h0);
    send(4);
    repeat (8) tick();
    a_if.clr_underrun = 1'b1;
    tick();
    chk("underrun_set_wins", {31'd0, a_if.underrun}, 32'h1);
    tick();
    chk("underrun_clear_next", {31'd0, a_if.underrun}, 32'h0);
    a_if.clr_underrun = 1'b0;

    // OCE gating: freeze 0xC3 at bit 3 for three edges, accept a word meanwhile
    send(5);
    repeat (4) tick();
    chk("gate_bit3", {31'd0, a_if.oq}, 32'h0);
    a_if.oce = 1'b0;
    send(0);
    chk("gate_accept_ready", {31'd0, a_if.d_ready}, 32'h0);
    chk("gate_hold_oq", {31'd0, a_if.oq}, 32'h0);
    tick();
    tick();
    chk("gate_hold_busy", {31'd0, a_if.busy}, 32'h1);
    chk("gate_hold_tq", {31'd0, a_if.tq}, 32'h0);
    a_if.oce = 1'b1;
    drain();
    chk("gate_busy_len", last_a, 32'd19);
    chk("gate_end_tq", {31'd0, a_if.tq}, 32'h1);
    chk("gate_underrun", {31'd0, a_if.underrun}, 32'h0);

    // four lanes in lockstep, then reset in the middle of a word
    send(6);
    drain();
    chk("lanes_busy_len", last_c, 32'd4);
    chk("lanes_end_oq", {28'd0, c_if.oq}, 32'hF);
    chk("lanes_end_tq", {28'd0, c_if.tq}, 32'hF);
    send(6);
    repeat (3) tick();
    chk("lanes_bit2", {28'd0, c_if.oq}, 32'h4);
    rst_c = 1'b0;
    #1;
    chk("midrst_oq", {28'd0, c_if.oq}, 32'hF);
    chk("midrst_tq", {28'd0, c_if.tq}, 32'hF);
    chk("midrst_ready", {31'd0, c_if.d_ready}, 32'h1);
    chk("midrst_busy", {31'd0, c_if.busy}, 32'h0);
    q_c.delete();
    tick();
    rst_c = 1'b1;
    repeat (10) tick();
    chk("postrst_busy", {31'd0, c_if.busy}, 32'h0);
    chk("postrst_tq", {28'd0, c_if.tq}, 32'hF);
    send(6);
    drain();
    chk("postrst_busy_len", last_c, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oserdes_gen.md
# oserdes_gen

Parametrised single-clock output serializer with a ready/valid parallel input and per-lane data and tristate outputs. It is the next-generation replacement for the fixed-ratio output serializer: width, lane count, bit order and idle behaviour are parameters, and it adds double buffering for gap-free streaming, frame-end marking and underrun detection. It sits between the parallel SoC-side data path and the pad/IO ring. Every lane is serialized in lockstep.

## Interface
- DATA_WIDTH, 8: bits per word per lane; legal range 2..16.
- LANES, 1: number of parallel serial lanes; legal range 1..8.
- MSB_FIRST, 0: 0 shifts out bit 0 first; 1 shifts out bit DATA_WIDTH-1 first.
- IDLE_VALUE, 1: OQ level while idle.
- TRISTATE_IDLE, 1: TQ level while idle; 1 means the pad is high-Z.

Ports:
- CLK  in  1  sole clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous reset, active-low; deassertion must be synchronous to CLK externally.
- D  in  DATA_WIDTH*LANES  parallel word; lane l uses D[l*DATA_WIDTH +: DATA_WIDTH].
- D_LAST  in  1  marks the word as the final word of a frame.
- D_VALID  in  1  D and D_LAST are valid.
- D_READY  out  1  the holding register is empty.
- OCE  in  1  shift enable; while low, the shift path freezes.
- CLR_UNDERRUN  in  1  clears the sticky UNDERRUN flag.
- OQ  out  LANES  serial data, registered.
- TQ  out  LANES  tristate control, registered; 0 means drive.
- BUSY  out  1  high while in SHIFT.
- UNDERRUN  out  1  sticky error flag.

## Operation
- Storage:
  - Holding register: HOLD, HOLD_LAST, HOLD_FULL.
  - Per-lane shift register holding the bits still to be shown.
  - CUR_LAST flag for the word being shifted.
  - Bit counter CNT, range 0..DATA_WIDTH-1; it indexes the bit currently on OQ.
- Handshake:
  - D_READY = !HOLD_FULL, decoded directly from the register (no combinational path from D_VALID).
  - Accept on an edge where D_VALID && D_READY: HOLD <= D, HOLD_LAST <= D_LAST, HOLD_FULL <= 1.
  - Acceptance is independent of OCE.
  - D must stay stable while D_VALID && !D_READY.
- States are IDLE and SHIFT. BUSY = (state == SHIFT).
- IDLE:
  - OQ = IDLE_VALUE and TQ = TRISTATE_IDLE on all lanes.
  - On an edge with OCE && HOLD_FULL, do a LOAD: go to SHIFT, CNT <= 0, OQ <= first bit of each lane, TQ <= 0, HOLD_FULL <= 0, CUR_LAST <= HOLD_LAST.
- SHIFT, edge with OCE and CNT < DATA_WIDTH-1:
  - CNT <= CNT+1.
  - OQ <= next bit in the order set by MSB_FIRST.
- SHIFT, edge with OCE and CNT == DATA_WIDTH-1 (end of word):
  - If HOLD_FULL: LOAD again. Stay in SHIFT with no idle bit between words.
  - Else: go to IDLE. OQ <= IDLE_VALUE, TQ <= TRISTATE_IDLE. If CUR_LAST == 0, set UNDERRUN.
- OCE low: state, CNT, the shift registers, OQ and TQ all hold.
- UNDERRUN:
  - Sticky; cleared on an edge with CLR_UNDERRUN.
  - If a set and a clear fall on the same edge, the set wins.
- Reset, asynchronous and effective mid-word:
  - Outputs: OQ = {LANES{IDLE_VALUE}}, TQ = {LANES{TRISTATE_IDLE}}, D_READY = 1, BUSY = 0, UNDERRUN = 0.
  - Internal: state IDLE, CNT 0, HOLD_FULL 0, CUR_LAST 0.
  - The word in flight is discarded.

## Timing
- Let E0 be the accept edge.
- The LOAD happens at E1 = E0+1 if OCE is high, and at the first later edge with OCE high otherwise.
- Bit i of the word is on OQ during the cycle after edge E1+i, for i = 0..DATA_WIDTH-1.
- Minimum latency from accept to the first bit appearing on OQ is 2 edges.
- With continuous OCE and a producer that always has data, output is gap-free:
  - D_READY rises the cycle after a LOAD.
  - DATA_WIDTH >= 2 guarantees the next word is accepted before the current word ends.
- Throughput is one word per DATA_WIDTH OCE-enabled cycles.
- TQ changes on the same edges as OQ.
- BUSY follows the state register with no extra delay.

## Test plan
- Single word: DATA_WIDTH=8, LANES=1, MSB_FIRST=0, D=0xA5, D_LAST=1, OCE=1.
  - OQ shows 1,0,1,0,0,1,0,1 after edges E1..E1+7, with TQ=0.
  - At E1+8, OQ=1 and TQ=1; BUSY spans exactly 8 cycles; UNDERRUN stays 0.
- Streaming, MSB_FIRST=1:
  - Words 0xF0, 0x0F, 0x3C back-to-back, last word with D_LAST=1.
  - 24 contiguous bits 11110000 00001111 00111100; TQ never rises between words.
- Underrun:
  - Send 0x55 with D_LAST=0 and no following word.
  - At the end-of-word edge, UNDERRUN=1 and the line is idle.
  - Pulse CLR_UNDERRUN: UNDERRUN=0. Set and clear on the same edge: UNDERRUN stays 1.
- OCE gating:
  - Drop OCE for 3 cycles at CNT=3 of 0xC3.
  - OQ holds bit 3 for 4 cycles in total, then resumes with bit 4; the total bit sequence is unchanged.
  - A new word is still accepted while OCE is low.
- Multi-lane and reset:
  - LANES=4, DATA_WIDTH=4, D=0x8421: lane 0 = 0x1, lane 1 = 0x2, lane 2 = 0x4, lane 3 = 0x8, serialized in lockstep.
  - Assert RST_N low at CNT=2: OQ=0xF and TQ=0xF immediately, D_READY=1, BUSY=0.
  - After reset, no leftover bits of the discarded word appear on OQ.
